// File: rtl/pool_pkg.sv
// Shared types and helpers for the 2x2 stride-2 pooling engine.
package pool_pkg;

    typedef enum logic {
        POOL_MODE_MAX = 1'b0,
        POOL_MODE_AVG = 1'b1
    } pool_mode_e;

    // Wide enough for any lane up to 64 bits, plus the two guard bits.
    localparam int POOL_ACC_W = 66;
    typedef logic signed [POOL_ACC_W-1:0] pool_acc_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int lane_w(input int data_width);
        return data_width + 1;
    endfunction

    // Max keeps the larger operand; average accumulates, scaling happens at the end.
    function automatic pool_acc_t pool_reduce(input pool_mode_e mode, input pool_acc_t a,
                                              input pool_acc_t b);
        if (mode == POOL_MODE_AVG) return a + b;
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pool_line_buffer.sv
// Half-line buffer holding the horizontally reduced pairs of the even row.
module pool_line_buffer #(
    parameter int DEPTH = 149,
    parameter int WIDTH = 33,
    parameter int AW    = 8
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/pool2x2_stream_multi.sv
// Streaming 2x2 / stride-2 max or average pooling over CHANNELS packed lanes.
module pool2x2_stream_multi
    import pool_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int CHANNELS       = 1,
    parameter int MAX_IMG_WIDTH  = 299,
    parameter int MAX_IMG_HEIGHT = 299
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     cfg_mode,
    input  logic [clog2(MAX_IMG_WIDTH+1)-1:0]        cfg_img_width,
    input  logic [clog2(MAX_IMG_HEIGHT+1)-1:0]       cfg_img_height,
    input  logic [CHANNELS*DATA_WIDTH-1:0]           Data_In,
    input  logic                                     Valid_In,
    output logic [CHANNELS*DATA_WIDTH-1:0]           Data_Out,
    output logic                                     Valid_Out,
    output logic                                     Frame_Done
);

    localparam int WW       = clog2(MAX_IMG_WIDTH + 1);
    localparam int HW       = clog2(MAX_IMG_HEIGHT + 1);
    localparam int LW       = lane_w(DATA_WIDTH);
    localparam int L2       = DATA_WIDTH + 2;
    localparam int LB_DEPTH = MAX_IMG_WIDTH / 2;
    localparam int AW       = (LB_DEPTH > 1) ? clog2(LB_DEPTH) : 1;

    pool_mode_e                   mode_r;
    logic                         active;
    logic [WW-1:0]                w_r, col, w_eff;
    logic [HW-1:0]                h_r, row, h_eff;
    logic [CHANNELS*DATA_WIDTH-1:0] hold, res;
    logic [CHANNELS*LW-1:0]       pair, lb_rd;
    logic                         in_area, col_end, last, lb_we;

    // The frame-start beat must already see the new geometry.
    assign w_eff   = active ? w_r : cfg_img_width;
    assign h_eff   = active ? h_r : cfg_img_height;
    assign in_area = (col < (w_eff & ~WW'(1))) && (row < (h_eff & ~HW'(1)));
    assign col_end = (col == w_eff - WW'(1));
    assign last    = col_end && (row == h_eff - HW'(1));
    assign lb_we   = Valid_In && in_area && col[0] && !row[0];

    // Odd columns are never the first beat, so mode_r is always valid here.
    for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
        logic signed [LW-1:0] pix_s, hold_s, pair_s, lb_s;
        logic signed [L2-1:0] res_s;

        assign pix_s  = {Data_In[k*DATA_WIDTH+DATA_WIDTH-1], Data_In[k*DATA_WIDTH +: DATA_WIDTH]};
        assign hold_s = {hold[k*DATA_WIDTH+DATA_WIDTH-1], hold[k*DATA_WIDTH +: DATA_WIDTH]};
        assign lb_s   = lb_rd[k*LW +: LW];
        assign pair_s = LW'(pool_reduce(mode_r, pool_acc_t'(hold_s), pool_acc_t'(pix_s)));
        assign res_s  = L2'(pool_reduce(mode_r, pool_acc_t'(lb_s), pool_acc_t'(pair_s)));
        assign pair[k*LW +: LW] = pair_s;
        assign res[k*DATA_WIDTH +: DATA_WIDTH] =
            (mode_r == POOL_MODE_AVG) ? res_s[L2-1:2] : res_s[DATA_WIDTH-1:0];
    end

    pool_line_buffer #(
        .DEPTH (LB_DEPTH),
        .WIDTH (CHANNELS*LW),
        .AW    (AW)
    ) u_line_buf (
        .clk     (clk),
        .wr_en   (lb_we),
        .wr_addr (col[AW:1]),
        .wr_data (pair),
        .rd_addr (col[AW:1]),
        .rd_data (lb_rd)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_r     <= POOL_MODE_MAX;
            active     <= 1'b0;
            w_r        <= '0;
            h_r        <= '0;
            col        <= '0;
            row        <= '0;
            hold       <= '0;
            Data_Out   <= '0;
            Valid_Out  <= 1'b0;
            Frame_Done <= 1'b0;
        end else begin
            Valid_Out  <= 1'b0;
            Frame_Done <= 1'b0;
            if (Valid_In) begin
                if (!active) begin
                    mode_r <= pool_mode_e'(cfg_mode);
                    w_r    <= cfg_img_width;
                    h_r    <= cfg_img_height;
                end
                if (last) begin
                    col    <= '0;
                    row    <= '0;
                    active <= 1'b0;
                end else begin
                    active <= 1'b1;
                    if (col_end) begin
                        col <= '0;
                        row <= row + HW'(1);
                    end else begin
                        col <= col + WW'(1);
                    end
                end
                Frame_Done <= last;
                if (in_area && !col[0]) hold <= Data_In;
                if (in_area && col[0] && row[0]) begin
                    Valid_Out <= 1'b1;
                    Data_Out  <= res;
                end
            end
        end
    end

endmodule

// File: tb/tb_pool2x2_stream_multi.sv
// Scoreboard bench: directed frames on a 1x32 instance and a 2x8 lane instance.
module tb_pool2x2_stream_multi;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    int          cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;

    logic        a_mode, a_vin, a_vout, a_fd;
    logic [8:0]  a_w, a_h;
    logic [31:0] a_din, a_dout;
    logic        b_mode, b_vin, b_vout, b_fd;
    logic [4:0]  b_w, b_h;
    logic [15:0] b_din, b_dout;

    exp_t        qa[$], qb[$];
    int          fda[$], fdb[$];
    logic [31:0] pix_q[$], exp_vals[$];
    exp_t        ea, eb;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pool2x2_stream_multi #(
        .DATA_WIDTH(32), .CHANNELS(1), .MAX_IMG_WIDTH(299), .MAX_IMG_HEIGHT(299)
    ) dut_a (
        .clk(clk), .rst(rst), .cfg_mode(a_mode), .cfg_img_width(a_w), .cfg_img_height(a_h),
        .Data_In(a_din), .Valid_In(a_vin), .Data_Out(a_dout), .Valid_Out(a_vout),
        .Frame_Done(a_fd)
    );

    pool2x2_stream_multi #(
        .DATA_WIDTH(8), .CHANNELS(2), .MAX_IMG_WIDTH(16), .MAX_IMG_HEIGHT(16)
    ) dut_b (
        .clk(clk), .rst(rst), .cfg_mode(b_mode), .cfg_img_width(b_w), .cfg_img_height(b_h),
        .Data_In(b_din), .Valid_In(b_vin), .Data_Out(b_dout), .Valid_Out(b_vout),
        .Frame_Done(b_fd)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever an output strobe shows up.
    always @(negedge clk) begin
        if (!rst) begin
            while (qa.size() > 0 && qa[0].cyc < cyc) begin
                check("A missing Valid_Out", 32'(qa[0].cyc), 32'(cyc));
                void'(qa.pop_front());
            end
            while (qb.size() > 0 && qb[0].cyc < cyc) begin
                check("B missing Valid_Out", 32'(qb[0].cyc), 32'(cyc));
                void'(qb.pop_front());
            end
            while (fda.size() > 0 && fda[0] < cyc) begin
                check("A missing Frame_Done", 32'(fda.pop_front()), 32'(cyc));
            end
            while (fdb.size() > 0 && fdb[0] < cyc) begin
                check("B missing Frame_Done", 32'(fdb.pop_front()), 32'(cyc));
            end
            if (a_vout) begin
                if (qa.size() == 0) check("A unexpected Valid_Out", 32'd1, 32'd0);
                else begin
                    ea = qa.pop_front();
                    check("A Data_Out", a_dout, ea.data);
                    check("A latency", 32'(cyc), 32'(ea.cyc));
                end
            end
            if (b_vout) begin
                if (qb.size() == 0) check("B unexpected Valid_Out", 32'd1, 32'd0);
                else begin
                    eb = qb.pop_front();
                    check("B Data_Out", {16'h0, b_dout}, eb.data);
                    check("B latency", 32'(cyc), 32'(eb.cyc));
                end
            end
            if (a_fd) begin
                if (fda.size() == 0) check("A unexpected Frame_Done", 32'd1, 32'd0);
                else check("A Frame_Done cycle", 32'(cyc), 32'(fda.pop_front()));
            end
            if (b_fd) begin
                if (fdb.size() == 0) check("B unexpected Frame_Done", 32'd1, 32'd0);
                else check("B Frame_Done cycle", 32'(cyc), 32'(fdb.pop_front()));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            a_vin = 1'b0;
            b_vin = 1'b0;
        end
    endtask

    // Drives n beats of a w x h frame from pix_q; expected outputs come from exp_vals.
    task automatic drive(input bit sel, input int w, input int h, input int n, input logic mode,
                         input bit gaps, input bit glitch);
        int r, c;
        r = 0;
        c = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (!sel) begin
                if (i == 0) begin a_mode = mode; a_w = 9'(w); a_h = 9'(h); end
                if (glitch && i == 4) begin a_mode = ~mode; a_w = 9'd2; a_h = 9'd2; end
                a_din = pix_q.pop_front();
                a_vin = 1'b1;
            end else begin
                if (i == 0) begin b_mode = mode; b_w = 5'(w); b_h = 5'(h); end
                b_din = pix_q.pop_front() & 32'hFFFF;
                b_vin = 1'b1;
            end
            if ((c % 2 == 1) && (r % 2 == 1) && (c < (w / 2) * 2) && (r < (h / 2) * 2)) begin
                if (!sel) qa.push_back('{exp_vals.pop_front(), cyc + 1});
                else      qb.push_back('{exp_vals.pop_front(), cyc + 1});
            end
            if (i == w * h - 1) begin
                if (!sel) fda.push_back(cyc + 1);
                else      fdb.push_back(cyc + 1);
            end
            c++;
            if (c == w) begin c = 0; r++; end
            if (gaps) repeat ($urandom_range(1, 3)) begin
                @(negedge clk);
                a_vin = 1'b0;
                b_vin = 1'b0;
            end
        end
    endtask

    task automatic load_ramp(input int n);
        for (int i = 0; i < n; i++) pix_q.push_back(32'(i));
    endtask

    initial begin
        rst = 1'b1;
        a_mode = 1'b0; a_w = '0; a_h = '0; a_din = '0; a_vin = 1'b0;
        b_mode = 1'b0; b_w = '0; b_h = '0; b_din = '0; b_vin = 1'b0;
        #1;
        check("reset A Data_Out", a_dout, 32'd0);
        check("reset A Valid_Out", {31'd0, a_vout}, 32'd0);
        check("reset A Frame_Done", {31'd0, a_fd}, 32'd0);
        check("reset B Data_Out", {16'h0, b_dout}, 32'd0);
        check("reset B Valid_Out", {31'd0, b_vout}, 32'd0);
        check("reset B Frame_Done", {31'd0, b_fd}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // 4x4 max
        load_ramp(16);
        exp_vals = '{32'd5, 32'd7, 32'd13, 32'd15};
        drive(1'b0, 4, 4, 16, 1'b0, 1'b0, 1'b0);
        idle(3);

        // 4x2 average with negative values
        pix_q = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd3, 32'd4,
                  32'hFFFF_FFFD, 32'hFFFF_FFFC, 32'd5, 32'd6};
        exp_vals = '{32'hFFFF_FFFD, 32'd4};
        drive(1'b0, 4, 2, 8, 1'b1, 1'b0, 1'b0);
        idle(3);

        // 5x3 max: trailing column and row ignored
        load_ramp(15);
        exp_vals = '{32'd6, 32'd8};
        drive(1'b0, 5, 3, 15, 1'b0, 1'b0, 1'b0);
        idle(3);

        // 4x4 max with idle gaps between beats
        load_ramp(16);
        exp_vals = '{32'd5, 32'd7, 32'd13, 32'd15};
        drive(1'b0, 4, 4, 16, 1'b0, 1'b1, 1'b0);
        idle(3);

        // Back-to-back: 4x4 max with mid-frame cfg change, then 2x2 avg
        load_ramp(16);
        pix_q.push_back(32'hFFFF_FFF9);
        pix_q.push_back(32'd2);
        pix_q.push_back(32'd3);
        pix_q.push_back(32'hFFFF_FFFF);
        exp_vals = '{32'd5, 32'd7, 32'd13, 32'd15, 32'hFFFF_FFFF};
        drive(1'b0, 4, 4, 16, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 2, 2, 4, 1'b1, 1'b0, 1'b0);
        idle(3);

        // 1x3 frame: no outputs, Frame_Done only
        pix_q = '{32'd9, 32'd9, 32'd9};
        drive(1'b0, 1, 3, 3, 1'b0, 1'b0, 1'b0);
        idle(3);

        // Two 8-bit lanes, lane1 = -lane0
        for (int i = 0; i < 16; i++) pix_q.push_back({16'h0, 8'(-i), 8'(i)});
        exp_vals = '{32'h0000_0005, 32'h0000_FE07, 32'h0000_F80D, 32'h0000_F60F};
        drive(1'b1, 4, 4, 16, 1'b0, 1'b0, 1'b0);
        idle(3);

        // Reset after 6 pixels of a 4x4 frame, then a fresh frame
        load_ramp(6);
        exp_vals = '{32'd5};
        drive(1'b0, 4, 4, 6, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        a_vin = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("mid-frame reset Data_Out", a_dout, 32'd0);
        check("mid-frame reset Valid_Out", {31'd0, a_vout}, 32'd0);
        check("mid-frame reset Frame_Done", {31'd0, a_fd}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        load_ramp(16);
        exp_vals = '{32'd5, 32'd7, 32'd13, 32'd15};
        drive(1'b0, 4, 4, 16, 1'b0, 1'b0, 1'b0);
        idle(5);

        check("A outputs drained", 32'(qa.size()), 32'd0);
        check("B outputs drained", 32'(qb.size()), 32'd0);
        check("A Frame_Done drained", 32'(fda.size()), 32'd0);
        check("B Frame_Done drained", 32'(fdb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pool2x2_stream_multi.md
Name: pool2x2_stream_multi

Overview:
- Streaming 2x2 / stride-2 pooling engine. It is the parametrised successor of the fixed 32-bit, 299x299 max-pool stage.
- Processes CHANNELS packed lanes per pixel. Selects max or average mode per frame.
- Takes image width/height at runtime, up to MAX_IMG_WIDTH, and discards odd trailing rows/columns.
- Sits after a convolution/activation stage in the raster-order pixel stream, one pixel per Valid_In beat.

Parameters:
- DATA_WIDTH, 32, signed two's-complement width of one channel sample.
- CHANNELS, 1, number of lanes packed per pixel; lane k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- MAX_IMG_WIDTH, 299, largest supported cfg_img_width; line buffer depth is MAX_IMG_WIDTH/2.
- MAX_IMG_HEIGHT, 299, largest supported cfg_img_height.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cfg_mode  in  1  0 = max, 1 = average; sampled at frame start.
- cfg_img_width  in  clog2(MAX_IMG_WIDTH+1)  input columns; sampled at frame start.
- cfg_img_height  in  clog2(MAX_IMG_HEIGHT+1)  input rows; sampled at frame start.
- Data_In  in  CHANNELS*DATA_WIDTH  input pixel.
- Valid_In  in  1  Data_In valid this cycle; no backpressure.
- Data_Out  out  CHANNELS*DATA_WIDTH  pooled pixel.
- Valid_Out  out  1  one-cycle strobe per pooled pixel.
- Frame_Done  out  1  one-cycle strobe after the last input pixel of a frame.

Behaviour:
- Reset (asynchronous, active-high): col/row counters = 0, hold register = 0, Data_Out = 0, Valid_Out = 0, Frame_Done = 0, frame-active flag = 0. Line buffer contents are don't-care.
- Reset asserted mid-frame: the partial frame is abandoned. The next Valid_In after deassertion is pixel (0,0) of a new frame.
- Frame start is the first Valid_In beat while frame-active = 0. On that beat: latch cfg_mode, W = cfg_img_width, H = cfg_img_height; set frame-active = 1. Config changes mid-frame have no effect.
- Each Valid_In beat advances col. col wraps W-1 -> 0 and increments row. Beat at (row H-1, col W-1) clears frame-active and both counters. Cycles with Valid_In = 0 change no state.
- Effective area: columns < (W & ~1), rows < (H & ~1). Pixels outside it are counted but ignored.
- Even col: store pixel into the hold register.
- Odd col: pair = reduce(hold, pixel) per lane.
  - Even row: write pair into line_buf[col>>1].
  - Odd row: result = reduce(line_buf[col>>1], pair), registered to Data_Out. Valid_Out = 1 on the next cycle.
- Latency: Valid_Out rises 1 cycle after the bottom-right pixel of each window is accepted. Output order is raster; (W/2)*(H/2) outputs per frame, floor division.
- Max mode: signed compare per lane. On a tie either operand is acceptable (values are equal). Line buffer and pair carry DATA_WIDTH+1 bits, sign-extended.
- Average mode: pair = sign-extended sum (DATA_WIDTH+1 bits). Total = DATA_WIDTH+2 bits, arithmetic shift right by 2 (floor toward −inf), truncated to DATA_WIDTH bits. Cannot overflow.
- Lanes are fully independent; no cross-lane arithmetic.
- Frame_Done = 1 for exactly one cycle, 1 cycle after the last pixel beat. It coincides with the final Valid_Out when W and H are both even.
- W < 2 or H < 2: no Valid_Out for that frame; Frame_Done still pulses.
- cfg values above MAX_* give undefined behaviour; the bench must not drive them.
- Back-to-back frames: pixel (0,0) of frame N+1 may arrive the cycle after the last pixel of frame N, with no bubble.
- Data_Out holds its last value while Valid_Out = 0.

Decomposition:
- Shared package pool_pkg:
  - POOL_MODE_MAX = 1'b0, POOL_MODE_AVG = 1'b1.
  - Function clog2.
  - Function for lane slice width DATA_WIDTH+1.
- One natural sub-module: pool_line_buffer. Simple dual-port, depth MAX_IMG_WIDTH/2, width CHANNELS*(DATA_WIDTH+1). Registered-address write, combinational read; inferable as distributed RAM or flops.
- The per-lane reduce function lives in pool_pkg. Everything else is in the top.

Test Plan:
- 4x4 max, CHANNELS=1, pixels 0..15 raster -> outputs 5, 7, 13, 15. Valid_Out 1 cycle after pixels 5, 7, 13, 15; Frame_Done after pixel 15.
- 4x2 avg, rows {-1,-2,3,4 / -3,-4,5,6} -> (-10)>>>2 = -3 and 18>>>2 = 4.
- 5x3 max, odd width and height, pixels 0..14 -> exactly 2 outputs: 6, 8. Column 4 and row 2 ignored; Frame_Done after pixel 14.
- Same 4x4 max frame with random Valid_In gaps (1-3 idle cycles) -> identical outputs and order. Each output 1 cycle after its bottom-right beat.
- Two back-to-back frames: frame A 4x4 max, frame B 2x2 avg, cfg changed mid-frame A -> A unaffected; B = floor(sum/4); two Frame_Done pulses.
- CHANNELS=2, DATA_WIDTH=8 max: lane0 values 0..15, lane1 = -(lane0) -> lane0 outputs 5, 7, 13, 15; lane1 outputs 0, -2, -8, -10.
- Extension case: rst asserted after 6 pixels of a 4x4 frame -> all outputs immediately 0. A fresh 4x4 frame then produces correct results.
